// File: rtl/pipeline_skid_reg.sv
// pipeline_skid_reg: two-entry pipeline stage register with valid/ready
// handshake, synchronous flush and a skid entry. in_ready is derived only
// from registered state plus the local reset/flush controls, so downstream
// back-pressure never reaches the producer combinationally.
module pipeline_skid_reg #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Stage state is named by how many entries are valid.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_v;
  logic             skid_v;
  logic             acc;
  logic             dlv;

  // The head entry always feeds the consumer; the skid entry only absorbs
  // the single beat that arrives while the consumer is stalled.
  assign out_valid = main_v;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  // Accepting is blocked while the skid slot is taken and during a
  // reset or flush cycle, so no beat can slip in alongside a kill.
  assign in_ready = ~skid_v & ~reset & ~flush;
  assign acc      = in_valid & in_ready;
  assign dlv      = out_valid & out_ready;

  // Occupancy-driven update of both entries; data registers load only on
  // the listed transitions and otherwise hold their value.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      case (occupancy)
        EMPTY: begin
          if (acc) begin
            main_data <= in_data;
            main_v    <= 1'b1;
          end
        end
        ONE: begin
          if (acc && dlv) begin
            main_data <= in_data;
          end else if (acc) begin
            skid_data <= in_data;
            skid_v    <= 1'b1;
          end else if (dlv) begin
            main_v    <= 1'b0;
          end
        end
        FULL: begin
          if (dlv) begin
            main_data <= skid_data;
            skid_v    <= 1'b0;
          end
        end
        default: begin
          main_v <= main_v;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Testbench for pipeline_skid_reg: a table of hand-derived corner-case
// vectors, a streaming sequence, and randomized traffic compared against a
// queue-based model of the stage. Three instances (32, 1 and 64 bits, the
// last with a non-zero reset value) share the same control stimulus.
module tb_pipeline_skid_reg;

  localparam logic [63:0] RV64 = 64'hA5A5_5A5A_F00D_C3C3;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic [63:0] in_data64;
  logic        in_data1;

  logic        in_ready, in_ready1, in_ready64;
  logic        out_valid, out_valid1, out_valid64;
  logic [31:0] out_data;
  logic        out_data1;
  logic [63:0] out_data64;
  logic [1:0]  occupancy, occupancy1, occupancy64;

  int check_count;
  int pass_count;

  // Model: queue of held beats (stored as the 64-bit payload) plus the value
  // left on out_data once the stage has drained.
  logic [63:0] model_q[$];
  logic [63:0] stale;
  bit          stale_is_reset;
  logic        ir_seen;

  pipeline_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipeline_skid_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occupancy1)
  );

  pipeline_skid_reg #(.WIDTH(64), .RESET_VAL(RV64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
    .occupancy(occupancy64)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  typedef struct {
    bit          reset;
    bit          flush;
    bit          in_valid;
    logic [31:0] in_data;
    bit          out_ready;
    bit          exp_in_ready;
    bit          exp_out_valid;
    logic [31:0] exp_out_data;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Expected head payload for a given instance width.
  function automatic logic [63:0] exp_data(input int w);
    logic [63:0] v;
    if (model_q.size() > 0) v = model_q[0];
    else if (stale_is_reset) begin
      if (w == 64) return RV64;
      return 64'd0;
    end else v = stale;
    if (w == 64) return v;
    if (w == 32) return {32'd0, v[63:32]};
    return {63'd0, v[32]};
  endfunction

  // Drives one cycle of inputs, checks in_ready before the edge, advances the
  // model, then checks all instances shortly after the edge.
  task automatic applyStimulus(input bit r, input bit f, input bit iv,
                               input logic [31:0] d, input bit ordy);
    bit          ir_exp;
    bit          acc;
    bit          dlv;
    logic [63:0] v64;
    int          sz;
    reset     = r;
    flush     = f;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = d;
    v64       = {d, ~d};
    in_data64 = v64;
    in_data1  = d[0];
    #1;
    ir_exp = !r && !f && (model_q.size() < 2);
    ir_seen = in_ready;
    checkOutput("in_ready32", {63'd0, in_ready}, {63'd0, ir_exp});
    checkOutput("in_ready1", {63'd0, in_ready1}, {63'd0, ir_exp});
    checkOutput("in_ready64", {63'd0, in_ready64}, {63'd0, ir_exp});
    acc = iv && ir_exp;
    dlv = (model_q.size() > 0) && ordy;
    if (r || f) begin
      model_q.delete();
      stale_is_reset = 1'b1;
    end else begin
      if (dlv) begin
        stale = model_q.pop_front();
        stale_is_reset = 1'b0;
      end
      if (acc) model_q.push_back(v64);
    end
    @(posedge clk);
    #1;
    sz = model_q.size();
    checkOutput("out_valid32", {63'd0, out_valid}, {63'd0, sz > 0});
    checkOutput("out_valid1", {63'd0, out_valid1}, {63'd0, sz > 0});
    checkOutput("out_valid64", {63'd0, out_valid64}, {63'd0, sz > 0});
    checkOutput("occupancy32", {62'd0, occupancy}, 64'(sz));
    checkOutput("occupancy1", {62'd0, occupancy1}, 64'(sz));
    checkOutput("occupancy64", {62'd0, occupancy64}, 64'(sz));
    checkOutput("out_data32", {32'd0, out_data}, exp_data(32));
    checkOutput("out_data1", {63'd0, out_data1}, exp_data(1));
    checkOutput("out_data64", out_data64, exp_data(64));
  endtask

  initial begin
    check_count    = 0;
    pass_count     = 0;
    clk            = 1'b0;
    stale          = 64'd0;
    stale_is_reset = 1'b1;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_data64 = '0; in_data1 = 1'b0;

    // Corner-case vectors: reset, stall absorb, flush, flush with delivery,
    // reset mid-stream, reset and flush together.
    //            rst flu iv  data        ordy ir  ov  out_data   occ
    vecs[0]  = '{1, 0, 0, 32'h0,  0, 0, 0, 32'h0, 2'd0};
    vecs[1]  = '{0, 0, 1, 32'hA,  1, 1, 1, 32'hA, 2'd1};
    vecs[2]  = '{0, 0, 1, 32'hB,  0, 1, 1, 32'hA, 2'd2};
    vecs[3]  = '{0, 0, 1, 32'hF,  0, 0, 1, 32'hA, 2'd2};
    vecs[4]  = '{0, 0, 0, 32'h0,  1, 0, 1, 32'hB, 2'd1};
    vecs[5]  = '{0, 0, 0, 32'h0,  1, 1, 0, 32'hB, 2'd0};
    vecs[6]  = '{0, 0, 1, 32'hC,  0, 1, 1, 32'hC, 2'd1};
    vecs[7]  = '{0, 0, 1, 32'hD,  0, 1, 1, 32'hC, 2'd2};
    vecs[8]  = '{0, 1, 1, 32'h99, 0, 0, 0, 32'h0, 2'd0};
    vecs[9]  = '{0, 0, 0, 32'h0,  0, 1, 0, 32'h0, 2'd0};
    vecs[10] = '{0, 0, 1, 32'hE,  0, 1, 1, 32'hE, 2'd1};
    vecs[11] = '{0, 1, 0, 32'h0,  1, 0, 0, 32'h0, 2'd0};
    vecs[12] = '{0, 0, 1, 32'h1,  0, 1, 1, 32'h1, 2'd1};
    vecs[13] = '{0, 0, 1, 32'h2,  0, 1, 1, 32'h1, 2'd2};
    vecs[14] = '{1, 0, 1, 32'h3,  0, 0, 0, 32'h0, 2'd0};
    vecs[15] = '{0, 0, 0, 32'h0,  0, 1, 0, 32'h0, 2'd0};
    vecs[16] = '{0, 0, 1, 32'h5,  0, 1, 1, 32'h5, 2'd1};
    vecs[17] = '{1, 1, 1, 32'h6,  0, 0, 0, 32'h0, 2'd0};

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].reset, vecs[i].flush, vecs[i].in_valid,
                    vecs[i].in_data, vecs[i].out_ready);
      checkOutput($sformatf("vec%0d in_ready", i), {63'd0, ir_seen},
                  {63'd0, vecs[i].exp_in_ready});
      checkOutput($sformatf("vec%0d out_valid", i), {63'd0, out_valid},
                  {63'd0, vecs[i].exp_out_valid});
      checkOutput($sformatf("vec%0d out_data", i), {32'd0, out_data},
                  {32'd0, vecs[i].exp_out_data});
      checkOutput($sformatf("vec%0d occupancy", i), {62'd0, occupancy},
                  {62'd0, vecs[i].exp_occ});
    end

    // Streaming 0x1..0x8 with the consumer always ready: each beat appears
    // one cycle after it is offered and the stage never holds two beats.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("reset out_data64", out_data64, RV64);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
      checkOutput($sformatf("stream in_ready %0d", i), {63'd0, ir_seen}, 64'd1);
      checkOutput($sformatf("stream out_data %0d", i), {32'd0, out_data}, 64'(i));
      checkOutput($sformatf("stream occ %0d", i), {62'd0, occupancy}, 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("stream drained", {63'd0, out_valid}, 64'd0);

    // Randomized traffic with occasional reset and flush.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 9) < 7), $urandom(),
                    ($urandom_range(0, 9) < 6));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
